// File: rtl/ex_flags_pkg.sv
// Shared definitions for the execute-stage flag unit: branch condition
// codes, flag bit positions and the branch condition evaluator.
package ex_flags_pkg;

    // Branch condition codes as carried on br_cond.
    typedef enum logic [2:0] {
        COND_NEQ   = 3'd0,
        COND_EQ    = 3'd1,
        COND_GT    = 3'd2,
        COND_LT    = 3'd3,
        COND_GTE   = 3'd4,
        COND_LTE   = 3'd5,
        COND_UNC   = 3'd6,
        COND_NEVER = 3'd7
    } cond_e;

    // Bit positions inside the flag word.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

    // Decide whether a branch with condition c is taken for the given
    // {N, Z} pair. Only the two evaluated bits are passed so the function
    // stays independent of the full flag word width.
    function automatic logic cond_eval(input cond_e c, input logic [1:0] zn);
        logic z;
        logic n;
        logic taken;
        z = zn[FLAG_Z];
        n = zn[FLAG_N];
        taken = 1'b0;
        case (c)
            COND_NEQ:   taken = ~z;
            COND_EQ:    taken = z;
            COND_GT:    taken = ~z & ~n;
            COND_LT:    taken = n;
            COND_GTE:   taken = ~n;
            COND_LTE:   taken = n | z;
            COND_UNC:   taken = 1'b1;
            COND_NEVER: taken = 1'b0;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_flag_stack.sv
// LIFO of saved flag contexts. Owns the storage array and the depth
// counter. Operations: push (i_push only), pop (i_pop only) and swap
// (both, only when non-empty). A push while full or a pop/swap while
// empty leaves the stack untouched; error reporting lives in the parent.
module ex_flag_stack
    import ex_flags_pkg::*;
#(
    parameter int FLAG_W = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [FLAG_W-1:0] i_wdata,
    output logic [FLAG_W-1:0] o_top,
    output logic [CNT_W-1:0]  o_depth,
    output logic              o_full,
    output logic              o_empty
);

    // Width needed to address DEPTH entries; at least one bit.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_depth;

    logic              w_full;
    logic              w_empty;
    logic              w_do_swap;
    logic              w_do_push;
    logic              w_do_pop;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;

    // Occupancy decode and operation qualification from the registered depth.
    always_comb begin
        w_full    = (r_depth == CNT_W'(DEPTH));
        w_empty   = (r_depth == '0);
        w_do_swap = i_push & i_pop & ~w_empty;
        w_do_push = i_push & ~i_pop & ~w_full;
        w_do_pop  = i_pop & ~i_push & ~w_empty;
        w_wr_idx  = IDX_W'(r_depth);
        w_top_idx = IDX_W'(r_depth - CNT_W'(1));
    end

    // Context storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_do_swap) begin
            r_mem[w_top_idx] <= i_wdata;
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    // Depth counter; a swap leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + CNT_W'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - CNT_W'(1);
        end
    end

    assign o_top   = r_mem[w_top_idx];
    assign o_depth = r_depth;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/ex_flags_unit.sv
// Execute-stage flag register with a nested interrupt context stack and a
// registered branch decision toward fetch. The branch is evaluated against
// the flags as they stand before this cycle's update.
module ex_flags_unit
    import ex_flags_pkg::*;
#(
    parameter int FLAG_W = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              cmp,
    input  logic              intr_entry,
    input  logic              returni,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic              err_clr,
    output logic [FLAG_W-1:0] flags_out,
    output logic              pc_branch_sel,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_udf
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_br_taken_p1;
    logic              r_err_ovf;
    logic              r_err_udf;

    logic [FLAG_W-1:0] w_eff;
    logic [FLAG_W-1:0] w_top;
    logic [CNT_W-1:0]  w_depth;
    logic              w_full;
    logic              w_empty;
    logic              w_restore;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic              w_taken_p0;

    ex_flag_stack #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (intr_entry),
        .i_pop   (returni),
        .i_wdata (w_eff),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Priority decode: a successful return (pop or swap) restores the saved
    // context and discards any cmp; every other case takes the effective flags.
    always_comb begin
        w_eff      = cmp ? flags_in : r_flags;
        w_restore  = returni & ~w_empty;
        w_udf_evt  = returni & w_empty;
        w_ovf_evt  = intr_entry & ~returni & w_full;
        w_taken_p0 = br_valid & cond_eval(cond_e'(br_cond),
                                          {r_flags[FLAG_N], r_flags[FLAG_Z]});
    end

    // Architectural flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_restore) begin
            r_flags <= w_top;
        end else begin
            r_flags <= w_eff;
        end
    end

    // Sticky error bits; a new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= (r_err_ovf & ~err_clr) | w_ovf_evt;
            r_err_udf <= (r_err_udf & ~err_clr) | w_udf_evt;
        end
    end

    // p0 -> p1: branch decision registered toward fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_taken_p1 <= 1'b0;
        end else begin
            r_br_taken_p1 <= w_taken_p0;
        end
    end

    assign flags_out     = r_flags;
    assign pc_branch_sel = r_br_taken_p1;
    assign depth         = w_depth;
    assign full          = w_full;
    assign empty         = w_empty;
    assign err_ovf       = r_err_ovf;
    assign err_udf       = r_err_udf;

endmodule

// File: doc/ex_flags_unit.md
Name: ex_flags_unit

Overview:
- Parametrised successor to the execute-stage flag register and branch-decision logic.
- Holds the architectural compare flags and a LIFO context stack of DEPTH saved flag words, giving nested interrupt entry/return instead of a single backup register.
- Evaluates the branch condition against the registered flags and produces a registered pc_branch_sel toward fetch.
- Sits in EX, beside the ALU wrapper; the ALU supplies flags_in, and decode control supplies cmp, intr_entry, returni and br_valid/br_cond.

Parameters:
- FLAG_W, 2, flag word width; bit0 = Z (zero), bit1 = N (negative); bits above 1 are carried and saved but never evaluated; FLAG_W must be >= 2.
- DEPTH, 4, number of saved flag contexts; must be >= 1.
- CNT_W, $clog2(DEPTH+1), width of the depth counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flags_in  in  FLAG_W  flag result from the ALU for the current EX instruction.
- cmp  in  1  the current instruction writes flags.
- intr_entry  in  1  interrupt entry: push a context.
- returni  in  1  interrupt return: pop a context.
- br_valid  in  1  the current instruction is a conditional branch.
- br_cond  in  3  branch condition code (cond_e).
- err_clr  in  1  clears the sticky error bits.
- flags_out  out  FLAG_W  registered architectural flags.
- pc_branch_sel  out  1  registered branch-taken pulse.
- depth  out  CNT_W  number of stacked contexts.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- err_ovf  out  1  sticky: push attempted while full.
- err_udf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst_n low at a rising edge): flags_out=0, depth=0, pc_branch_sel=0, err_ovf=0, err_udf=0. Stack contents are don't-care. Reset overrides every other input in the same cycle, including mid-nesting.
- Define eff = cmp ? flags_in : flags_out.
- All state updates on the rising edge. Priority per cycle:
  - push & pop, depth>=1: flags_out <= top entry; top <= eff; depth unchanged. This is the swap case for a back-to-back return plus re-entry.
  - push & pop, depth==0: treated as an underflowing pop. err_udf <= 1; flags_out <= eff; nothing is pushed.
  - pop only, depth>=1: flags_out <= top; depth--. Any cmp that cycle is discarded (the restore wins).
  - pop only, depth==0: err_udf <= 1; flags_out <= eff; depth stays 0.
  - push only, depth<DEPTH: stack[depth] <= eff; flags_out <= eff; depth++. The handler inherits the current flags.
  - push only, depth==DEPTH: err_ovf <= 1; stack untouched; flags_out <= eff.
  - neither: flags_out <= eff.
- err_clr clears both sticky bits. An error event in the same cycle as err_clr wins (bit stays 1).
- full and empty decode combinationally from the registered depth.
- Branch evaluation:
  - taken = br_valid & cond(br_cond, flags_out), using pre-update flags. A cmp in the same cycle does not affect that cycle's branch.
  - pc_branch_sel <= taken; one-cycle latency; one-cycle pulse per branch.
- Conditions (Z=flags_out[0], N=flags_out[1]):
  - NEQ = !Z
  - EQ = Z
  - GT = !Z & !N
  - LT = N
  - GTE = !N
  - LTE = N | Z
  - UNC = 1
  - NEVER = 0
- No combinational path from any input to any output.

Decomposition:
- Package ex_flags_pkg:
  - cond_e enum, 3 bits: NEQ=0, EQ=1, GT=2, LT=3, GTE=4, LTE=5, UNC=6, NEVER=7.
  - Constants FLAG_Z=0, FLAG_N=1.
  - Pure function cond_eval(cond_e, flags) returning taken.
- Sub-module ex_flag_stack:
  - Parametrised LIFO (FLAG_W, DEPTH), owning the storage array and the depth counter.
  - Ops: push, pop, swap.
  - Outputs: top, full, empty.
  - Same clk/rst_n.
- ex_flags_unit holds flags_out, the error bits, the priority decode and the branch register.

Test Plan:
- Reset then cmp with flags_in=2'b01 -> flags_out=01 next cycle; br_valid with EQ the following cycle -> pc_branch_sel=1 one cycle later, then 0.
- flags=01; intr_entry -> depth=1; cmp with flags_in=10 -> flags_out=10; returni -> flags_out=01, depth=0, empty=1.
- DEPTH=4: five pushes with cmp values 1,2,3,0,1 -> depth=4, full=1, err_ovf=1 after the 5th push, stack unchanged; four pops restore 0,3,2,1 in order.
- Pop while empty -> err_udf=1, depth=0, flags_out unchanged; err_clr -> err_udf=0; err_clr together with another underflow -> err_udf stays 1.
- depth=1 holding 10, flags_out=01, push+pop in one cycle -> flags_out=10, top=01, depth=1.
- depth=3, rst_n low for 1 cycle -> depth=0, flags_out=0, errors 0; cmp in the same cycle as a branch (flags=00 to 01, cond EQ) -> not taken.
